// File: rtl/ws_pe_pkg.sv
// Shared widths and helpers for the weight-stationary PE datapath.
// Holds the constant clog2 and the clamp used when narrowing accumulator results.
package ws_pe_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_OUT_W = 8;

  // Widest accumulator sat_narrow can clamp; callers sign-extend into it.
  localparam int NARROW_W = 64;

  typedef struct packed {
    logic signed [NARROW_W-1:0] value;
    logic                       sat;
  } narrow_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic narrow_t sat_narrow(input logic signed [NARROW_W-1:0] total,
                                         input int out_w);
    logic signed [NARROW_W-1:0] one;
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    narrow_t r;
    one     = NARROW_W'(1);
    hi      = (one <<< (out_w - 1)) - one;
    lo      = -(one <<< (out_w - 1));
    r.value = total;
    r.sat   = 1'b0;
    if (total > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (total < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ws_psum_accum_if.sv
// Beat-in / result-out handshake bundle of the partial-sum accumulator.
// master is the PE-array side that drives beats and consumes results; slave is the accumulator.
interface ws_psum_accum_if
  import ws_pe_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_IN*IN_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;
  logic                     busy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/ws_adder_tree.sv
// Combinational signed reduction of NUM_IN packed lanes into one sum.
// SUM_W defaults to the width at which the reduction can never overflow.
module ws_adder_tree
  import ws_pe_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int IN_W   = DEF_IN_W,
  parameter int SUM_W  = IN_W + clog2(NUM_IN)
) (
  input  logic [NUM_IN*IN_W-1:0] data,
  output logic signed [SUM_W-1:0] sum
);
  logic signed [IN_W-1:0] lanes [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lanes[i] = data[i*IN_W +: IN_W];
  end

  always_comb begin
    // NOTE: default assignment first so this combinational block can never infer a latch.
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum = sum + SUM_W'(lanes[i]);
    end
  end
endmodule

// File: rtl/ws_psum_accum.sv
// Partial-sum accumulator: registered lane reduction, ACC_LEN-beat accumulation, valid/ready result register.
// Define WS_ACCUM_SAT_EN to saturate the narrowed result (out_sat flags clipping); otherwise it wraps.
module ws_psum_accum
  import ws_pe_pkg::*;
#(
  parameter int NUM_IN  = 3,
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_LEN = 3,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input logic            sys_clk,
  input logic            CLR,
  ws_psum_accum_if.slave bus
);
  localparam int SUM_W     = IN_W + clog2(NUM_IN);
  localparam int MIN_ACC_W = SUM_W + clog2(ACC_LEN);
  localparam int CNT_W     = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

  if (NUM_IN < 1 || ACC_LEN < 1) begin : g_bad_counts
    $error("ws_psum_accum: NUM_IN and ACC_LEN must be at least 1");
  end
  if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
    $error("ws_psum_accum: ACC_W too small for NUM_IN/IN_W/ACC_LEN");
  end
  if (OUT_W > ACC_W) begin : g_bad_out_w
    $error("ws_psum_accum: OUT_W must not exceed ACC_W");
  end

  logic                    stall;
  logic                    accept;
  logic                    final_beat;
  logic signed [SUM_W-1:0] tree_sum;
  logic                    s1_v;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] total;
  logic [CNT_W-1:0]        beat_cnt;
  logic [OUT_W-1:0]        narrow_val;
  logic                    narrow_sat;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    out_sat_q;

  ws_adder_tree #(
    .NUM_IN (NUM_IN),
    .IN_W   (IN_W),
    .SUM_W  (SUM_W)
  ) u_tree (
    .data (bus.in_data),
    .sum  (tree_sum)
  );

  // A held result freezes the whole pipeline so no beat is lost or duplicated.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign final_beat   = !stall && !bus.flush && s1_v && (beat_cnt == LAST_BEAT);
  assign total        = acc + ACC_W'(s1_sum);

`ifdef WS_ACCUM_SAT_EN
  narrow_t nr;
  assign nr         = sat_narrow(NARROW_W'(total), OUT_W);
  assign narrow_val = nr.value[OUT_W-1:0];
  assign narrow_sat = nr.sat;
`else
  assign narrow_val = total[OUT_W-1:0];
  assign narrow_sat = 1'b0;
`endif

  // Flush drops the partial group, including a beat still sitting in stage 1.
  always_ff @(posedge sys_clk or posedge CLR) begin
    // NOTE: non-blocking (<=) for all state so every register samples pre-edge values.
    if (CLR) begin
      s1_v     <= 1'b0;
      s1_sum   <= '0;
      acc      <= '0;
      beat_cnt <= '0;
    end else if (bus.flush) begin
      s1_v     <= 1'b0;
      acc      <= '0;
      beat_cnt <= '0;
    end else if (!stall) begin
      s1_v   <= accept;
      s1_sum <= tree_sum;
      if (s1_v) begin
        if (beat_cnt == LAST_BEAT) begin
          acc      <= '0;
          beat_cnt <= '0;
        end else begin
          acc      <= total;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  // A completing group may overwrite a result being taken this cycle, giving back-to-back output.
  always_ff @(posedge sys_clk or posedge CLR) begin
    if (CLR) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (final_beat) begin
      out_valid_q <= 1'b1;
      out_data_q  <= narrow_val;
      out_sat_q   <= narrow_sat;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = (beat_cnt != '0) || s1_v;
endmodule
